// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter sharing one sequential Booth multiplier among NREQ clients
module booth_mult_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [RW-1:0]     rsp_result,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic              mul_done,
    input  logic [RW-1:0]     mul_result
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_pick;
    logic [IW:0]   w_sum;
    logic          w_found;
    logic          w_timeout;
    logic [7:0]    r_wd;
    logic [RW-1:0] r_result;
    logic          r_err;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;

    // Scan last+1, last+2, ... modulo NREQ; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            if (!w_found && req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    assign w_timeout = (r_wd == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        gnt       = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                gnt[r_owner] = 1'b1;
                mul_start    = 1'b1;
                w_next       = S_WAIT;
            end
            // done is only looked at here so a stale level from the last op is skipped
            S_WAIT: begin
                if (mul_done || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner  <= '0;
            r_last   <= IW'(NREQ - 1);
            r_wd     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_x     <= req_x[w_pick*W +: W];
                        r_y     <= req_y[w_pick*W +: W];
                    end
                end
                S_ISSUE: r_wd <= '0;
                S_WAIT: begin
                    if (mul_done) begin
                        r_result <= mul_result;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_owner]) r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign rsp_result = r_result;
    assign rsp_err    = r_err;
    assign mul_x      = r_x;
    assign mul_y      = r_y;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - randomized self-checking bench for booth_mult_arbiter
module tb_booth_mult_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 8;
    localparam int RW      = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [RW-1:0]     rsp_result;
    logic              rsp_err;
    logic              mul_start;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic              mul_done;
    logic [RW-1:0]     mul_result;

    logic [W-1:0] x_op [NREQ];
    logic [W-1:0] y_op [NREQ];
    int           m_last;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_x[i*W +: W] = x_op[i];
        assign req_y[i*W +: W] = y_op[i];
    end

    booth_mult_arbiter #(
        .NREQ(NREQ), .W(W), .RW(RW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .mul_start(mul_start),
        .mul_x(mul_x), .mul_y(mul_y), .mul_done(mul_done), .mul_result(mul_result)
    );

    function automatic int exp_owner(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    // Signed W x W product, low RW bits
    function automatic logic [RW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [RW-1:0] sa;
        logic signed [RW-1:0] sb;
        sa = {{(RW-W){a[W-1]}}, a};
        sb = {{(RW-W){b[W-1]}}, b};
        return sa * sb;
    endfunction

    task automatic run_txn(input logic [NREQ-1:0] pat, input int delay, input bit leave_high,
                           input int ready_wait, input bit keep_req, input bit other_req);
        int            exp;
        int            t;
        int            cyc;
        int            exp_cyc;
        bit            pre;
        bit            early;
        logic [NREQ-1:0] eg;
        logic [RW-1:0] exp_res;
        logic          exp_err;
        exp = exp_owner(pat);
        eg = '0;
        eg[exp] = 1'b1;
        pre = mul_done;
        early = 1'b0;
        if (delay < 0) begin
            exp_res = '0;
            exp_err = 1'b1;
            exp_cyc = TIMEOUT + 1;
        end else begin
            exp_res = prod(x_op[exp], y_op[exp]);
            exp_err = 1'b0;
            exp_cyc = pre ? 2 : delay + 1;
        end
        req = pat;
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (gnt == '0 && t < 10);
        n_tests++;
        if (gnt !== eg || t != 1) begin
            n_fail++;
            $display("FAIL gnt: got %b after %0d cycles, want %b after 1", gnt, t, eg);
        end
        n_tests++;
        if (mul_start !== 1'b1 || mul_x !== x_op[exp] || mul_y !== y_op[exp]) begin
            n_fail++;
            $display("FAIL issue: start=%b x=%h y=%h, want start=1 x=%h y=%h",
                     mul_start, mul_x, mul_y, x_op[exp], y_op[exp]);
        end
        if (!keep_req) req[exp] = 1'b0;
        x_op[exp] = W'($urandom);
        y_op[exp] = W'($urandom);
        cyc = 0;
        if (pre) begin
            mul_result = prod(mul_x, mul_y);
        end else if (delay > 0) begin
            repeat (delay) begin
                @(posedge clk); #1; cyc++;
                if (rsp_valid != '0) early = 1'b1;
            end
            mul_result = prod(mul_x, mul_y);
            mul_done = 1'b1;
        end
        do begin
            @(posedge clk); #1; cyc++;
        end while (rsp_valid == '0 && cyc < 64);
        n_tests++;
        if (rsp_valid !== eg || cyc != exp_cyc || early) begin
            n_fail++;
            $display("FAIL rsp_timing: valid=%b at cycle %0d early=%0b, want %b at cycle %0d",
                     rsp_valid, cyc, early, eg, exp_cyc);
        end
        n_tests++;
        if (rsp_result !== exp_res || rsp_err !== exp_err) begin
            n_fail++;
            $display("FAIL rsp_data: result=%h err=%b, want result=%h err=%b",
                     rsp_result, rsp_err, exp_res, exp_err);
        end
        n_tests++;
        if (gnt !== '0 || mul_start !== 1'b0) begin
            n_fail++;
            $display("FAIL exclusive: gnt=%b start=%b in RESP, want 0 0", gnt, mul_start);
        end
        if (!leave_high) mul_done = 1'b0;
        for (int i = 0; i < ready_wait; i++) begin
            rsp_ready = ~eg;
            if (other_req) req = req | ~eg;
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== eg || rsp_result !== exp_res || rsp_err !== exp_err || gnt !== '0) begin
                n_fail++;
                $display("FAIL rsp_hold: valid=%b result=%h err=%b gnt=%b, want %b %h %b 00",
                         rsp_valid, rsp_result, rsp_err, gnt, eg, exp_res, exp_err);
            end
        end
        rsp_ready = eg;
        @(posedge clk); #1;
        rsp_ready = '0;
        n_tests++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL rsp_release: valid=%b after ready, want 0", rsp_valid);
        end
        m_last = exp;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        rsp_ready = '0;
        mul_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_reset();
        mul_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            x_op[i] = '0;
            y_op[i] = '0;
        end
        do_reset();
        n_tests++;
        if (gnt !== '0 || rsp_valid !== '0 || mul_start !== 1'b0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b valid=%b start=%b err=%b, want all 0",
                     gnt, rsp_valid, mul_start, rsp_err);
        end
        n_tests++;
        if (rsp_result !== '0 || mul_x !== '0 || mul_y !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h x=%h y=%h, want 0", rsp_result, mul_x, mul_y);
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if (gnt !== '0) begin
                n_fail++;
                $display("FAIL idle_no_req: gnt=%b, want 00", gnt);
            end
        end
    endtask

    task automatic test_basic();
        x_op[0] = 8'd7;
        y_op[0] = 8'hFD;
        run_txn(2'b01, 6, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if (gnt !== '0 || rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL basic_idle: gnt=%b valid=%b, want 00 00", gnt, rsp_valid);
            end
        end
    endtask

    task automatic test_fairness();
        int order [4];
        do_reset();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                x_op[i] = W'($urandom);
                y_op[i] = W'($urandom);
            end
            run_txn(2'b11, $urandom_range(1, 5), 1'b0, 0, 1'b1, 1'b0);
            order[n] = m_last;
        end
        req = '0;
        n_tests++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            n_fail++;
            $display("FAIL fairness: order %0d %0d %0d %0d, want 0 1 0 1",
                     order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_done_held();
        x_op[1] = W'($urandom);
        y_op[1] = W'($urandom);
        run_txn(2'b10, 3, 1'b1, 0, 1'b0, 1'b0);
        x_op[0] = W'($urandom);
        y_op[0] = W'($urandom);
        run_txn(2'b01, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        mul_result = 16'hA5A5;
        x_op[1] = W'($urandom);
        y_op[1] = W'($urandom);
        run_txn(2'b10, -1, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure();
        x_op[0] = W'($urandom);
        y_op[0] = W'($urandom);
        x_op[1] = W'($urandom);
        y_op[1] = W'($urandom);
        run_txn(2'b01, 4, 1'b0, 10, 1'b0, 1'b1);
        run_txn(2'b10, 2, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int t;
        x_op[0] = 8'h5A;
        y_op[0] = 8'h3C;
        req = 2'b01;
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (gnt == '0 && t < 10);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== '0 || rsp_valid !== '0 || mul_start !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_result !== '0 || mul_x !== '0 || mul_y !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: gnt=%b valid=%b start=%b err=%b result=%h x=%h y=%h, want all 0",
                     gnt, rsp_valid, mul_start, rsp_err, rsp_result, mul_x, mul_y);
        end
        rst = 1'b1;
        m_last = NREQ - 1;
        x_op[1] = W'($urandom);
        y_op[1] = W'($urandom);
        run_txn(2'b10, 3, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pat;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                x_op[i] = W'($urandom);
                y_op[i] = W'($urandom);
            end
            pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(pat, $urandom_range(1, 8), 1'b0, $urandom_range(0, 3), 1'b0, 1'b0);
            req = '0;
        end
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        rsp_ready = '0;
        mul_done = 1'b0;
        mul_result = '0;
        m_last = NREQ - 1;
        test_reset();
        test_basic();
        test_fairness();
        test_done_held();
        test_timeout();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one sequential Booth multiplier (datapath plus its start/done controller) among NREQ requesters.
- Arbitrates round-robin, captures the winner's operands, pulses the multiplier start, waits for done, then returns the product to the winner over a valid/ready response.
- A watchdog bounds the wait on the multiplier. The block sits between client blocks and the single multiplier instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 8, operand width (X and Y).
- RW, 16, result width (2*W).
- TIMEOUT, 15, max cycles in WAIT before abort (1..255); counter width 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- req  input  NREQ  per-requester request level; hold until gnt bit seen.
- req_x  input  NREQ*W  operand X, requester i at bits [i*W +: W].
- req_y  input  NREQ*W  operand Y, same packing.
- gnt  output  NREQ  one-hot, one-cycle pulse: requester's operands captured.
- rsp_valid  output  NREQ  one-hot; result pending for that requester.
- rsp_ready  input  NREQ  per-requester accept.
- rsp_result  output  RW  shared result bus, valid when any rsp_valid bit is set.
- rsp_err  output  1  qualifies rsp_result: 1 = watchdog abort, result forced 0.
- mul_start  output  1  one-cycle start pulse to the multiplier controller.
- mul_x  output  W  registered operand X to the multiplier.
- mul_y  output  W  registered operand Y to the multiplier.
- mul_done  input  1  multiplier done (level or pulse).
- mul_result  input  RW  multiplier product, valid with mul_done.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; gnt, rsp_valid, mul_start = 0; rsp_err = 0.
  - rsp_result, mul_x, mul_y = 0.
  - last = NREQ-1, so requester 0 has top priority after reset.
  - Watchdog counter = 0.
  - Reset mid-operation aborts the transaction silently, with no response. The multiplier is not reset by this block.
- State machine, Moore outputs, one transition per clock:
  - IDLE:
    - If req != 0, pick the first set bit scanning last+1, last+2, ... modulo NREQ; record it as owner.
    - Load mul_x/mul_y from the owner's slice and go to ISSUE.
    - If req == 0, stay in IDLE.
  - ISSUE, exactly 1 cycle: gnt[owner]=1, mul_start=1, watchdog cleared; go to WAIT.
  - WAIT:
    - mul_done is sampled only here, never in ISSUE, so a level-high done left over from the previous operation is ignored for one cycle.
    - On mul_done=1: latch mul_result into rsp_result, set rsp_err=0, go to RESP.
    - Otherwise the watchdog increments. When it reaches TIMEOUT: rsp_result=0, rsp_err=1, go to RESP.
  - RESP:
    - rsp_valid[owner]=1; rsp_result and rsp_err are held stable.
    - When rsp_ready[owner]=1: set last=owner and go to IDLE. rsp_valid drops the next cycle.
    - rsp_ready bits of non-owners are ignored.
- Latency: from req sampled in IDLE at edge t, gnt and mul_start are high in cycle t+1. Minimum req-to-rsp_valid is 3 cycles plus the multiplier time.
- Operands: mul_x/mul_y are stable from ISSUE until the next IDLE load. Requester inputs may change after gnt.
- Request rules:
  - A req deasserted before gnt is simply not serviced.
  - req is not sampled outside IDLE; the owner re-requesting while in RESP is arbitrated in the next IDLE.
  - gnt and rsp_valid are never asserted together.
- Fairness: with all req bits held high, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Width: rsp_result = mul_result, RW bits, no truncation. Sign interpretation belongs to the multiplier.
- Back-pressure: RESP may last indefinitely; no new transaction starts until it is accepted.

Test Plan:
- Reset, then req=01, X0=8'd7, Y0=8'hFD, mul_done 6 cycles after mul_start with result 16'hFFEB -> gnt=01 and mul_start in cycle 1, mul_x=7, mul_y=FD, rsp_valid=01, rsp_result=FFEB, rsp_err=0, idle after rsp_ready=01.
- req=11 held, 4 transactions, immediate rsp_ready -> gnt order 01,10,01,10.
- mul_done held high from the previous op -> not accepted in ISSUE; accepted in the first WAIT cycle.
- mul_done never asserted, TIMEOUT=15 -> rsp_valid after 15 WAIT cycles, rsp_result=0, rsp_err=1.
- rsp_ready low for 10 cycles in RESP while the other requester asserts req -> rsp_result stable, no gnt until ready, then the other requester is granted.
- rst=0 during WAIT -> all outputs 0 next cycle; after release, req=10 is granted with requester 0 idle.
